// File: rtl/lcd_pkg.sv
// Shared definitions for the LCD bus arbiter: controller state encoding,
// default timing constants (50 MHz clock), HD44780 command codes that need
// the long post-write wait, and the phase counter width.
package lcd_pkg;

  localparam int unsigned CNT_W = 20;

  localparam int unsigned DEF_INIT_CYC  = 1_000_000;  // 20 ms power-up
  localparam int unsigned DEF_SETUP_CYC = 4;
  localparam int unsigned DEF_EN_CYC    = 25;         // 500 ns
  localparam int unsigned DEF_HOLD_CYC  = 4;
  localparam int unsigned DEF_CMD_WAIT  = 2_500;      // 50 us
  localparam int unsigned DEF_LONG_WAIT = 100_000;    // 2 ms

  localparam logic [7:0] CLEAR = 8'h01;
  localparam logic [7:0] HOME  = 8'h02;

  typedef enum logic [2:0] {
    POWERUP,
    IDLE,
    SETUP,
    EN_HI,
    HOLD,
    WAIT
  } lcd_state_t;

  // Clear-display and return-home are the slow instructions.
  function automatic logic is_long_cmd(input logic rs, input logic [7:0] data);
    return !rs && ((data == CLEAR) || (data == HOME));
  endfunction

endpackage

// File: rtl/lcd_phase_timer.sv
// Loadable down-counter shared by every controller phase.
//   clk, rst  : clock, async active-high reset (clears the count)
//   load      : load load_val this cycle (takes priority over counting)
//   load_val  : phase length minus one
//   done      : count has reached zero (last cycle of the phase)
module lcd_phase_timer
  import lcd_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             done
);

  logic [CNT_W-1:0] count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (count != '0) begin
      count <= count - 1'b1;
    end
  end

  assign done = (count == '0);

endmodule

// File: rtl/lcd_bus_arbiter.sv
// Two-port write arbiter for an HD44780-style LCD bus.
//   clk, rst              : 50 MHz clock, async active-high reset
//   req0/rs0/data0/ack0   : requester 0 write request, RS, byte, done pulse
//   req1/rs1/data1/ack1   : requester 1, same as requester 0
//   lcd_en/lcd_rs/lcd_rw/lcd_data : LCD bus (write-only, lcd_rw tied low)
//   busy                  : high whenever the controller is not in IDLE
// Arbitration happens only in IDLE, round-robin on contention. The winner's
// RS/byte are registered at grant and held on the bus until the next grant.
module lcd_bus_arbiter
  import lcd_pkg::*;
#(
  parameter int unsigned INIT_CYC  = DEF_INIT_CYC,
  parameter int unsigned SETUP_CYC = DEF_SETUP_CYC,
  parameter int unsigned EN_CYC    = DEF_EN_CYC,
  parameter int unsigned HOLD_CYC  = DEF_HOLD_CYC,
  parameter int unsigned CMD_WAIT  = DEF_CMD_WAIT,
  parameter int unsigned LONG_WAIT = DEF_LONG_WAIT
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req0,
  input  logic       rs0,
  input  logic [7:0] data0,
  output logic       ack0,
  input  logic       req1,
  input  logic       rs1,
  input  logic [7:0] data1,
  output logic       ack1,
  output logic       lcd_en,
  output logic       lcd_rs,
  output logic       lcd_rw,
  output logic [7:0] lcd_data,
  output logic       busy
);

  lcd_state_t       state, nxt;
  logic             pu_armed;   // POWERUP counter has been loaded
  logic             ptr;        // port favoured on contention
  logic             sel;        // port owning the current bus cycle
  logic             grant;
  logic             grant_port;
  logic             tmr_load;
  logic [CNT_W-1:0] tmr_val;
  logic             tmr_done;

  lcd_phase_timer u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (tmr_load),
    .load_val (tmr_val),
    .done     (tmr_done)
  );

  always_comb begin
    nxt        = state;
    tmr_load   = 1'b0;
    tmr_val    = '0;
    grant      = 1'b0;
    grant_port = ptr;
    unique case (state)
      // Reset leaves the counter at zero, so the first POWERUP cycle is
      // spent loading it; that cycle counts toward INIT_CYC.
      POWERUP: begin
        if (!pu_armed) begin
          if (INIT_CYC == 1) begin
            nxt = IDLE;
          end else begin
            tmr_load = 1'b1;
            tmr_val  = CNT_W'(INIT_CYC - 2);
          end
        end else if (tmr_done) begin
          nxt = IDLE;
        end
      end
      IDLE: begin
        if (req0 || req1) begin
          grant      = 1'b1;
          grant_port = (req0 && req1) ? ptr : req1;
          nxt        = SETUP;
          tmr_load   = 1'b1;
          tmr_val    = CNT_W'(SETUP_CYC - 1);
        end
      end
      SETUP: begin
        if (tmr_done) begin
          nxt      = EN_HI;
          tmr_load = 1'b1;
          tmr_val  = CNT_W'(EN_CYC - 1);
        end
      end
      EN_HI: begin
        if (tmr_done) begin
          nxt      = HOLD;
          tmr_load = 1'b1;
          tmr_val  = CNT_W'(HOLD_CYC - 1);
        end
      end
      HOLD: begin
        if (tmr_done) begin
          nxt      = WAIT;
          tmr_load = 1'b1;
          tmr_val  = is_long_cmd(lcd_rs, lcd_data) ? CNT_W'(LONG_WAIT - 1)
                                                   : CNT_W'(CMD_WAIT - 1);
        end
      end
      WAIT: begin
        if (tmr_done) begin
          nxt = IDLE;
        end
      end
      default: nxt = POWERUP;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= POWERUP;
      pu_armed <= 1'b0;
      ptr      <= 1'b0;
      sel      <= 1'b0;
      lcd_rs   <= 1'b0;
      lcd_data <= '0;
    end else begin
      state <= nxt;
      if (state == POWERUP) begin
        pu_armed <= 1'b1;
      end
      if (grant) begin
        ptr      <= ~grant_port;
        sel      <= grant_port;
        lcd_rs   <= grant_port ? rs1 : rs0;
        lcd_data <= grant_port ? data1 : data0;
      end
    end
  end

  // Decoded straight from registered state so reset clears them at once.
  assign lcd_en = (state == EN_HI);
  assign lcd_rw = 1'b0;
  assign busy   = (state != IDLE);
  assign ack0   = (state == WAIT) && tmr_done && !sel;
  assign ack1   = (state == WAIT) && tmr_done && sel;

endmodule

// File: tb/tb_lcd_bus_arbiter.sv
module tb_lcd_bus_arbiter;

  localparam int unsigned INIT_CYC  = 10;
  localparam int unsigned SETUP_CYC = 2;
  localparam int unsigned EN_CYC    = 3;
  localparam int unsigned HOLD_CYC  = 2;
  localparam int unsigned CMD_WAIT  = 5;
  localparam int unsigned LONG_WAIT = 20;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       req0 = 1'b0, rs0 = 1'b0, req1 = 1'b0, rs1 = 1'b0;
  logic [7:0] data0 = '0, data1 = '0;
  logic       ack0, ack1, lcd_en, lcd_rs, lcd_rw, busy;
  logic [7:0] lcd_data;

  int errors = 0;
  int checks = 0;

  lcd_bus_arbiter #(
    .INIT_CYC  (INIT_CYC),
    .SETUP_CYC (SETUP_CYC),
    .EN_CYC    (EN_CYC),
    .HOLD_CYC  (HOLD_CYC),
    .CMD_WAIT  (CMD_WAIT),
    .LONG_WAIT (LONG_WAIT)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .req0     (req0),
    .rs0      (rs0),
    .data0    (data0),
    .ack0     (ack0),
    .req1     (req1),
    .rs1      (rs1),
    .data1    (data1),
    .ack1     (ack1),
    .lcd_en   (lcd_en),
    .lcd_rs   (lcd_rs),
    .lcd_rw   (lcd_rw),
    .lcd_data (lcd_data),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int port, input logic r, input logic rs, input logic [7:0] d);
    if (port == 0) begin
      req0 = r; rs0 = rs; data0 = d;
    end else begin
      req1 = r; rs1 = rs; data1 = d;
    end
  endtask

  // One write from a single port: waits for IDLE, then counts cycles from
  // the grant cycle (cycle 1) to the ack cycle.
  task automatic do_write(input string tag, input int port, input logic rs,
                          input logic [7:0] d, input int exp_lat, input bit perturb);
    int n, en_cnt, guard;
    bit got_ack, other_ack, bus_bad;
    set_req(port, 1'b1, rs, d);
    guard = 0;
    while (busy && guard < 2000) begin
      tick();
      guard++;
    end
    check({tag, "_reach_idle"}, busy, 0);
    n = 1; en_cnt = 0; got_ack = 0; other_ack = 0; bus_bad = 0;
    while (!got_ack && n < 500) begin
      tick();
      n++;
      if (perturb && n == 2) begin
        // late input change and early req drop must not disturb the cycle
        set_req(port, 1'b0, ~rs, 8'hFF);
      end
      if (lcd_en) en_cnt++;
      if (lcd_rs !== rs || lcd_data !== d || lcd_rw !== 1'b0) bus_bad = 1;
      if ((port == 0) ? ack1 : ack0) other_ack = 1;
      if ((port == 0) ? ack0 : ack1) got_ack = 1;
    end
    set_req(port, 1'b0, rs, d);
    check({tag, "_latency"}, n, exp_lat);
    check({tag, "_en_width"}, en_cnt, EN_CYC);
    check({tag, "_bus_stable"}, bus_bad, 0);
    check({tag, "_other_ack"}, other_ack, 0);
    tick();
    check({tag, "_ack_single"}, (port == 0) ? ack0 : ack1, 0);
  endtask

  // Hold the reset-to-IDLE window: busy for INIT_CYC-1 samples, IDLE at INIT_CYC.
  task automatic powerup_window(input string tag);
    bit early;
    early = 0;
    for (int k = 1; k < INIT_CYC; k++) begin
      tick();
      if (!busy || lcd_en || ack0 || ack1) early = 1;
    end
    check({tag, "_no_early_activity"}, early, 0);
    tick();
    check({tag, "_idle_at_init"}, busy, 0);
  endtask

  // Both ports held high; records the order of ack pulses.
  task automatic contend(input string tag, input int n_grants, input int first);
    int seen, guard, exp_port;
    bit overlap, prev0, prev1, stretch, order_bad, data_bad;
    set_req(0, 1'b1, 1'b1, 8'h30);
    set_req(1, 1'b1, 1'b1, 8'h31);
    seen = 0; guard = 0; overlap = 0; prev0 = 0; prev1 = 0;
    stretch = 0; order_bad = 0; data_bad = 0;
    exp_port = first;
    while (seen < n_grants && guard < 2000) begin
      tick();
      guard++;
      if (ack0 && ack1) overlap = 1;
      if ((ack0 && prev0) || (ack1 && prev1)) stretch = 1;
      if (ack0 || ack1) begin
        if ((ack1 ? 1 : 0) != exp_port) order_bad = 1;
        if (lcd_data !== (ack1 ? 8'h31 : 8'h30)) data_bad = 1;
        exp_port = 1 - exp_port;
        seen++;
      end
      prev0 = ack0;
      prev1 = ack1;
    end
    set_req(0, 1'b0, 1'b1, 8'h30);
    set_req(1, 1'b0, 1'b1, 8'h31);
    check({tag, "_grant_count"}, seen, n_grants);
    check({tag, "_alternation"}, order_bad, 0);
    check({tag, "_ack_overlap"}, overlap, 0);
    check({tag, "_ack_single"}, stretch, 0);
    check({tag, "_winner_data"}, data_bad, 0);
    tick();
    check({tag, "_ack_clear"}, ack0 | ack1, 0);
  endtask

  initial begin
    int guard;
    bit saw_ack;

    // Reset state, with port 0 already requesting.
    set_req(0, 1'b1, 1'b1, 8'h41);
    tick();
    tick();
    check("rst_lcd_en", lcd_en, 0);
    check("rst_lcd_rs", lcd_rs, 0);
    check("rst_lcd_rw", lcd_rw, 0);
    check("rst_lcd_data", lcd_data, 8'h00);
    check("rst_acks", {ack0, ack1}, 2'b00);
    check("rst_busy", busy, 1);
    rst = 1'b0;

    // Power-up: request pending through POWERUP, served once IDLE is reached.
    powerup_window("pwr");
    do_write("pwr_write", 0, 1'b1, 8'h41, 13, 0);

    do_write("clear", 0, 1'b0, 8'h01, 28, 0);
    do_write("normal_cmd", 0, 1'b0, 8'h38, 13, 0);
    do_write("data_01", 0, 1'b1, 8'h01, 13, 0);
    do_write("home_p1", 1, 1'b0, 8'h02, 28, 0);
    do_write("cmd_03", 1, 1'b0, 8'h03, 13, 0);

    // Pointer after reset favoured 0; last grant now port 1 -> 0 wins first.
    do_write("p1_again", 1, 1'b1, 8'h55, 13, 0);
    contend("contend", 4, 0);

    // Last grant port 0 -> pointer at port 1 -> port 1 wins, then port 0.
    do_write("p0_single", 0, 1'b1, 8'h45, 13, 0);
    contend("ptr_at_1", 2, 1);

    // Inputs changed and req dropped one cycle after grant.
    do_write("late_change", 0, 1'b1, 8'h5A, 13, 1);

    // Reset during EN_HI.
    set_req(0, 1'b1, 1'b1, 8'h52);
    guard = 0;
    while (!lcd_en && guard < 200) begin
      tick();
      guard++;
    end
    check("mid_reached_en", lcd_en, 1);
    #1 rst = 1'b1;
    #1;
    check("mid_rst_en_drop", lcd_en, 0);
    check("mid_rst_busy", busy, 1);
    check("mid_rst_ack", {ack0, ack1}, 2'b00);
    tick();
    tick();
    check("mid_rst_data_clr", lcd_data, 8'h00);
    rst = 1'b0;
    powerup_window("mid_pwr");
    saw_ack = ack0;
    check("mid_no_ack", saw_ack, 0);
    do_write("mid_resume", 0, 1'b1, 8'h52, 13, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/lcd_bus_arbiter.md
LCD_BUS_ARBITER -- requirements
Module: lcd_bus_arbiter

Interface
REQ-001 The block SHALL use one clock and one reset, where the reset is asynchronous and active-high.
REQ-002 Parameter INIT_CYC, default 1_000_000, power-up delay (20 ms at 50 MHz) before the first bus cycle.
REQ-003 Parameter SETUP_CYC, default 4, cycles RS/DATA are stable before EN rises.
REQ-004 Parameter EN_CYC, default 25, EN high width (500 ns).
REQ-005 Parameter HOLD_CYC, default 4, cycles RS/DATA are held after EN falls.
REQ-006 Parameter CMD_WAIT, default 2_500, post-write wait for normal writes (50 us).
REQ-007 Parameter LONG_WAIT, default 100_000, post-write wait for clear/home commands (2 ms).
REQ-008 Ports SHALL be:
- clk  in  1  system clock (50 MHz)
- rst  in  1  async active-high reset
- req0  in  1  requester 0 write request
- rs0  in  1  requester 0 RS (0 = command, 1 = data)
- data0  in  8  requester 0 byte
- ack0  out  1  requester 0 completion pulse
- req1, rs1, data1, ack1: as for requester 0
- lcd_en  out  1  LCD enable
- lcd_rs  out  1  LCD register select
- lcd_rw  out  1  LCD read/write, constant 0
- lcd_data  out  8  LCD data bus
- busy  out  1  high in every state except IDLE

Function
REQ-009 The FSM states SHALL be POWERUP, IDLE, SETUP, EN_HI, HOLD and WAIT.
REQ-010 FSM transitions SHALL be:
- POWERUP → IDLE after INIT_CYC cycles.
- IDLE → SETUP on the cycle any req is sampled high.
- SETUP → EN_HI after SETUP_CYC cycles.
- EN_HI → HOLD after EN_CYC cycles.
- HOLD → WAIT after HOLD_CYC cycles.
- WAIT → IDLE after the selected wait count.
REQ-011 Requests asserted during POWERUP SHALL be held pending, not dropped, and SHALL be served once IDLE is reached.
REQ-012 Arbitration SHALL occur only in IDLE: a single request wins; with both requests high, the port not granted last wins (round-robin).
REQ-013 After reset, the round-robin pointer SHALL favour port 0.
REQ-014 In the IDLE grant cycle, the winner's rs and data SHALL be latched, and lcd_rs/lcd_data SHALL take those values on the next edge.
REQ-015 lcd_rs and lcd_data SHALL stay stable until the next grant, whatever the requester inputs do.
REQ-016 lcd_en SHALL be 1 only in EN_HI, giving exactly EN_CYC cycles high; the LCD latches on the falling edge.
REQ-017 The wait count SHALL be LONG_WAIT when the latched rs = 0 and data = 8'h01 or 8'h02; otherwise it SHALL be CMD_WAIT.
REQ-018 The granted port's ack SHALL be high for exactly one cycle, the final WAIT cycle; the other port's ack SHALL stay 0.
REQ-019 Grant-to-ack latency SHALL be 1 + SETUP_CYC + EN_CYC + HOLD_CYC + wait count cycles, with the grant cycle counted as cycle 1.
REQ-020 A requester SHALL hold req, rs and data until its ack; it may keep req high after ack to issue a back-to-back write, which is then arbitrated in the next IDLE cycle.
REQ-021 A req deasserted before grant SHALL be ignored; a req deasserted after grant SHALL NOT abort the cycle, and ack still pulses.
REQ-022 Simultaneous new requests with the pointer at port 1 SHALL grant port 1 and then move the pointer to port 0.
REQ-023 Phase counters SHALL be 20-bit; each parameter SHALL be ≥ 1 and < 2^20.

Reset
REQ-024 While rst = 1, the outputs SHALL be: lcd_en = 0, lcd_rs = 0, lcd_rw = 0, lcd_data = 8'h00, ack0 = ack1 = 0, busy = 1.
REQ-025 While rst = 1, the state SHALL be POWERUP with the counter cleared and the pointer at port 0.
REQ-026 Reset asserted mid-cycle, including during EN_HI, SHALL drop lcd_en asynchronously and abandon the write with no ack.
REQ-027 After reset releases, the full INIT_CYC delay SHALL be repeated.

Structure
REQ-028 Shared package lcd_pkg SHALL hold: the state enum, the default timing constants, and the command codes CLEAR = 8'h01 and HOME = 8'h02.
REQ-029 One sub-module, lcd_phase_timer, SHALL be instantiated: a loadable 20-bit down-counter with a done flag, reused for every phase.

Verification
(INIT_CYC = 10, SETUP_CYC = 2, EN_CYC = 3, HOLD_CYC = 2, CMD_WAIT = 5, LONG_WAIT = 20)
REQ-030 Power-up: req0 = 1, rs0 = 1, data0 = 8'h41 from reset release -> no lcd_en before cycle 10; lcd_en high for exactly 3 cycles with lcd_rs = 1 and lcd_data = 8'h41; ack0 pulses once, 13 cycles after grant.
REQ-031 Long wait: port 0 writes rs0 = 0, data0 = 8'h01 -> grant-to-ack latency is 28 cycles.
REQ-032 Normal command: port 0 writes rs0 = 0, data0 = 8'h38 -> grant-to-ack latency is 13 cycles.
REQ-033 Contention: req0 and req1 held high continuously -> grants alternate 0,1,0,1; each ack is a single-cycle pulse; the acks never overlap.
REQ-034 Input change after grant: data0 changes to 8'hFF one cycle after grant -> lcd_data keeps the originally latched byte through the entire cycle.
REQ-035 Reset mid-cycle: rst asserted during EN_HI -> lcd_en = 0 in the same cycle; no ack; the next write waits a full 10-cycle power-up delay.
